// File: rtl/word_tx_stream_if.sv
// Word-in / byte-out handshake bundle for word_tx_stream.
// master drives words and uart_tx acknowledges; slave is the transmitter.
interface word_tx_stream_if #(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned FIFO_DEPTH = 4
) ();
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [8*WORD_BYTES-1:0] in;
   logic                    in_valid;
   logic                    in_ready;
   logic [7:0]              out;
   logic                    send_out;
   logic                    sent;
   logic                    done;
   logic                    busy;
   logic [CNT_W-1:0]        fifo_count;

   modport master (
      output in, in_valid, sent,
      input  in_ready, out, send_out, done, busy, fifo_count
   );

   modport slave (
      input  in, in_valid, sent,
      output in_ready, out, send_out, done, busy, fifo_count
   );
endinterface

// File: rtl/word_tx_stream.sv
// Buffers WORD_BYTES-wide words in a FIFO and serialises them byte-by-byte to uart_tx.
// Define WORD_TX_CHECKSUM_EN to append an XOR checksum byte after every word.
module word_tx_stream #(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MSB_FIRST  = 0
) (
   input logic             clk,
   input logic             rst,
   word_tx_stream_if.slave bus
);
   localparam int unsigned W     = 8 * WORD_BYTES;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef WORD_TX_CHECKSUM_EN
   localparam int unsigned LAST  = WORD_BYTES;
`else
   localparam int unsigned LAST  = WORD_BYTES - 1;
`endif
   localparam int unsigned IDX_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   logic [W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   state_t           state;
   logic [W-1:0]     word;
   logic [IDX_W-1:0] idx;
   logic [7:0]       out_q;
   logic             send_out_q;
   logic             done_q;
   logic             busy_q;
`ifdef WORD_TX_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   logic             push_c;
   logic             pop_c;
   logic [W-1:0]     head_c;
   logic [IDX_W-1:0] idx_nxt_c;
   logic [7:0]       byte_nxt_c;

   // Transmit-order index to data byte, honouring MSB_FIRST.
   function automatic logic [7:0] sel_byte(input logic [W-1:0] w, input logic [IDX_W-1:0] i);
      logic [7:0] b;
      b = '0;
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
         if (i == IDX_W'((MSB_FIRST != 0) ? (WORD_BYTES - 1 - k) : k)) b = w[8*k +: 8];
      end
      return b;
   endfunction

`ifdef WORD_TX_CHECKSUM_EN
   function automatic logic [7:0] xor_bytes(input logic [W-1:0] w);
      logic [7:0] x;
      x = '0;
      for (int unsigned k = 0; k < WORD_BYTES; k++) x = x ^ w[8*k +: 8];
      return x;
   endfunction
`endif

   assign bus.in_ready   = (count != CNT_W'(FIFO_DEPTH));
   assign bus.fifo_count = count;
   assign bus.out        = out_q;
   assign bus.send_out   = send_out_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_q;

   assign push_c = bus.in_valid && bus.in_ready;
   assign pop_c  = (state == IDLE) && (count != '0);
   assign head_c = mem[rd_ptr];

   // Byte to present after the current one is acknowledged.
   always_comb begin
      idx_nxt_c = idx + 1'b1;
`ifdef WORD_TX_CHECKSUM_EN
      byte_nxt_c = (idx_nxt_c == IDX_W'(WORD_BYTES)) ? csum : sel_byte(word, idx_nxt_c);
`else
      byte_nxt_c = sel_byte(word, idx_nxt_c);
`endif
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + 1'b1;
         if (pop_c)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= bus.in;
   end

   // Serialiser FSM; the word register is loaded only on pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         word       <= '0;
         idx        <= '0;
         out_q      <= 8'h00;
         send_out_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef WORD_TX_CHECKSUM_EN
         csum       <= 8'h00;
`endif
      end else begin
         send_out_q <= 1'b0;
         done_q     <= 1'b0;
         case (state)
            IDLE: begin
               if (pop_c) begin
                  word       <= head_c;
                  idx        <= '0;
                  out_q      <= sel_byte(head_c, '0);
                  send_out_q <= 1'b1;
                  busy_q     <= 1'b1;
`ifdef WORD_TX_CHECKSUM_EN
                  csum       <= xor_bytes(head_c);
`endif
                  state      <= SEND;
               end
            end
            SEND: state <= WAIT;
            WAIT: begin
               if (bus.sent) begin
                  if (idx == IDX_W'(LAST)) begin
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     idx        <= idx_nxt_c;
                     out_q      <= byte_nxt_c;
                     send_out_q <= 1'b1;
                     state      <= SEND;
                  end
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_word_tx_stream.sv
// Bench for word_tx_stream: LSB-first and MSB-first instances share stimulus and are
// scored against per-instance expected byte queues built from each pushed word.
module tb_word_tx_stream;
   localparam int unsigned WB = 4;
   localparam int unsigned FD = 4;
`ifdef WORD_TX_CHECKSUM_EN
   localparam int BPW = WB + 1;
`else
   localparam int BPW = WB;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [8*WB-1:0] in_word;
   logic          in_valid;
   logic          sent;
   bit            sent_stray;

   word_tx_stream_if #(.WORD_BYTES(WB), .FIFO_DEPTH(FD)) i0 ();
   word_tx_stream_if #(.WORD_BYTES(WB), .FIFO_DEPTH(FD)) i1 ();

   assign i0.in       = in_word;
   assign i0.in_valid = in_valid;
   assign i0.sent     = sent;
   assign i1.in       = in_word;
   assign i1.in_valid = in_valid;
   assign i1.sent     = sent;

   word_tx_stream #(.WORD_BYTES(WB), .FIFO_DEPTH(FD), .MSB_FIRST(0)) dut0 (
      .clk(clk), .rst(rst), .bus(i0));
   word_tx_stream #(.WORD_BYTES(WB), .FIFO_DEPTH(FD), .MSB_FIRST(1)) dut1 (
      .clk(clk), .rst(rst), .bus(i1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp0[$];
   logic [7:0] exp1[$];
   int  acked, dones, sends, cd, resp_delay;
   bit  resp_en, rand_delay, stray_req;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected byte stream of one word for each byte order, plus optional XOR byte.
   task automatic push_model(input logic [8*WB-1:0] w);
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < int'(WB); k++) begin
         exp0.push_back(8'((w >> (8*k)) & 'hFF));
         exp1.push_back(8'((w >> (8*(int'(WB)-1-k))) & 'hFF));
         x = x ^ 8'((w >> (8*k)) & 'hFF);
      end
`ifdef WORD_TX_CHECKSUM_EN
      exp0.push_back(x);
      exp1.push_back(x);
`endif
   endtask

   // One clock: model update, output scoring, then uart_tx responder drive.
   task automatic tick();
      bit acc, sent_edge, stray_edge, rst_edge, exp_done;
      acc        = in_valid && i0.in_ready && !rst;
      sent_edge  = sent;
      stray_edge = sent_stray;
      rst_edge   = rst;
      @(posedge clk);
      #1;
      if (rst_edge) begin
         exp0.delete();
         exp1.delete();
         acked = 0;
         cd    = 0;
      end else begin
         if (acc) push_model(in_word);
         exp_done = 1'b0;
         if (sent_edge && !stray_edge) begin
            acked++;
            exp_done = ((acked % BPW) == 0);
         end
         if (i0.done || exp_done) check("done_lsb", 32'(i0.done), 32'(exp_done));
         if (i1.done || exp_done) check("done_msb", 32'(i1.done), 32'(exp_done));
         if (i0.done) dones++;
         if (i0.send_out) begin
            sends++;
            if (exp0.size() == 0) check("send_out_unexpected_lsb", 1, 0);
            else check("out_lsb", 32'(i0.out), 32'(exp0.pop_front()));
         end
         if (i1.send_out) begin
            if (exp1.size() == 0) check("send_out_unexpected_msb", 1, 0);
            else check("out_msb", 32'(i1.out), 32'(exp1.pop_front()));
         end
      end
      sent       = 1'b0;
      sent_stray = 1'b0;
      if (i0.send_out && stray_req) begin
         sent       = 1'b1;
         sent_stray = 1'b1;
         stray_req  = 1'b0;
      end
      if (i0.send_out && resp_en) cd = rand_delay ? int'($urandom_range(6, 2)) : resp_delay;
      if (cd > 0) begin
         cd--;
         if (cd == 0) sent = 1'b1;
      end
   endtask

   task automatic run_until_dones(input int target, input int max_cycles);
      int n;
      n = 0;
      while (dones < target && n < max_cycles) begin
         tick();
         n++;
      end
      check("dones_reached", 32'(dones), 32'(target));
   endtask

   task automatic push_one(input logic [8*WB-1:0] w);
      in_word  = w;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [8*WB-1:0] w6 [6];
      int k, base, base_sends, pushed;
      bit acc;

      rst = 1'b1; in_valid = 1'b0; in_word = '0; sent = 1'b0; sent_stray = 1'b0;
      acked = 0; dones = 0; sends = 0; cd = 0;
      resp_en = 1'b0; rand_delay = 1'b0; stray_req = 1'b0; resp_delay = 10;
      tick();
      tick();
      check("rst_in_ready", 32'(i0.in_ready), 1);
      check("rst_fifo_count", 32'(i0.fifo_count), 0);
      check("rst_out", 32'(i0.out), 0);
      check("rst_send_out", 32'(i0.send_out), 0);
      check("rst_done", 32'(i0.done), 0);
      check("rst_busy", 32'(i0.busy), 0);
      rst = 1'b0;

      // Directed word, both byte orders, sent replied 10 cycles after each send_out.
      resp_en = 1'b1;
      push_one(32'hAABBCCDD);
      check("push_count", 32'(i0.fifo_count), 1);
      check("pre_pop_send_out", 32'(i0.send_out), 0);
      tick();
      check("latency_send_out", 32'(i0.send_out), 1);
      check("first_byte_lsb", 32'(i0.out), 32'h0000_00DD);
      check("first_byte_msb", 32'(i1.out), 32'h0000_00AA);
      check("pop_count", 32'(i0.fifo_count), 0);
      run_until_dones(1, 200);
      check("busy_during_done", 32'(i0.busy), 1);
      tick();
      check("busy_after_done", 32'(i0.busy), 0);
      check("done_single", 32'(i0.done), 0);
      check("queue_drained", 32'(exp0.size()), 0);

      // Stray sent in IDLE, then one coincident with send_out.
      sent = 1'b1; sent_stray = 1'b1;
      tick();
      tick();
      check("idle_sent_busy", 32'(i0.busy), 0);
      check("idle_sent_count", 32'(i0.fifo_count), 0);
      stray_req = 1'b1; rand_delay = 1'b1;
      push_one(32'h01020304);
      run_until_dones(dones + 1, 300);
      tick();
      check("stray_busy_after", 32'(i0.busy), 0);

      // Withhold sent, overfill the FIFO, then release.
      resp_en = 1'b0;
      for (int i = 0; i < 6; i++) w6[i] = 32'($urandom);
      k = 0;
      base = dones;
      base_sends = sends;
      for (int c = 0; c < 20; c++) begin
         in_valid = (k < 6);
         in_word  = w6[k % 6];
         acc = in_valid && i0.in_ready;
         tick();
         if (acc) k++;
      end
      check("full_pushed", 32'(k), 5);
      check("full_count", 32'(i0.fifo_count), 4);
      check("full_in_ready", 32'(i0.in_ready), 0);
      check("full_busy", 32'(i0.busy), 1);
      cd = 2; resp_en = 1'b1;
      for (int c = 0; c < 1500 && dones < base + 6; c++) begin
         in_valid = (k < 6);
         in_word  = w6[k % 6];
         acc = in_valid && i0.in_ready;
         tick();
         if (acc) k++;
      end
      in_valid = 1'b0;
      check("drain_pushed", 32'(k), 6);
      check("drain_dones", 32'(dones - base), 6);
      check("drain_sends", 32'(sends - base_sends), 32'(6 * BPW));

      // Reset in WAIT of the second byte with three words buffered.
      tick();
      resp_en = 1'b0;
      for (int i = 0; i < 4; i++) push_one(32'($urandom));
      cd = 2;
      for (int c = 0; c < 6; c++) tick();
      check("pre_rst_count", 32'(i0.fifo_count), 3);
      check("pre_rst_busy", 32'(i0.busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_send_out", 32'(i0.send_out), 0);
      check("mid_rst_out", 32'(i0.out), 0);
      check("mid_rst_count", 32'(i0.fifo_count), 0);
      check("mid_rst_busy", 32'(i0.busy), 0);
      check("mid_rst_in_ready", 32'(i0.in_ready), 1);
      sent = 1'b1; sent_stray = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      check("late_sent_busy", 32'(i0.busy), 0);
      resp_en = 1'b1;
      push_one(32'h5A6B7C8D);
      run_until_dones(dones + 1, 300);

      // Randomized traffic and acknowledgement latency.
      base = dones;
      pushed = 0;
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(3, 0) == 0);
         in_word  = 32'($urandom);
         acc = in_valid && i0.in_ready;
         tick();
         if (acc) pushed++;
      end
      in_valid = 1'b0;
      run_until_dones(base + pushed, 3000);
      tick();
      check("rand_end_count", 32'(i0.fifo_count), 0);
      check("rand_end_busy", 32'(i0.busy), 0);
      check("rand_end_queue", 32'(exp0.size() + exp1.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
